// File: rtl/nibble_packer_if.sv
// Nibble-in / word-out handshake bundle for nibble_packer.
// The packer uses the slave modport; producer/consumer logic uses master.
interface nibble_packer_if;
  logic        in_valid;
  logic [3:0]  in_nib;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_word;
  logic [3:0]  out_count;
  logic        out_ready;
  logic [4:0]  nctr;

  modport slave (
    input  in_valid, in_nib, flush, out_ready,
    output in_ready, out_valid, out_word, out_count, nctr
  );

  modport master (
    output in_valid, in_nib, flush, out_ready,
    input  in_ready, out_valid, out_word, out_count, nctr
  );
endinterface

// File: rtl/nibble_packer.sv
// Packs 4-bit nibbles into 32-bit words, LSB nibble first, with ready/valid on both sides.
// A flush closes a partial word early; unwritten slots keep PAD_VAL.
module nibble_packer #(
  parameter logic [3:0] PAD_VAL = 4'h0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  nibble_packer_if.slave   bus
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [4:0]  nctr_q, nctr_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  count_q, count_d;
  logic        accept;

  assign accept = bus.in_valid && (state_q == FILL);

  always_comb begin
    state_d = state_q;
    nctr_d  = nctr_q;
    word_d  = word_q;
    count_d = count_q;
    if (state_q == FILL) begin
      if (accept) begin
        word_d[nctr_q +: 4] = bus.in_nib;
      end
      // The 8th accept wins over a same-cycle flush, so count is always 8 there.
      if (accept && (nctr_q == 5'd28)) begin
        nctr_d  = 5'd0;
        count_d = 4'd8;
        state_d = FULL;
      end else if (bus.flush && ((nctr_q != 5'd0) || accept)) begin
        nctr_d  = 5'd0;
        count_d = {1'b0, nctr_q[4:2]} + {3'b000, accept};
        state_d = FULL;
      end else if (accept) begin
        nctr_d = nctr_q + 5'd4;
      end
    end else begin
      if (bus.out_ready) begin
        state_d = FILL;
        word_d  = {8{PAD_VAL}};
        count_d = 4'd0;
        nctr_d  = 5'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FILL;
      nctr_q  <= 5'd0;
      word_q  <= {8{PAD_VAL}};
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      nctr_q  <= nctr_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_word  = word_q;
  assign bus.out_count = count_q;
  assign bus.nctr      = nctr_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed test of nibble_packer: full words, flush corner cases, backpressure and reset.
module tb_nibble_packer;

  logic clk;
  logic reset;
  int   checkCnt;
  int   passCnt;
  int   failCnt;

  nibble_packer_if bus ();
  nibble_packer_if busF ();

  nibble_packer #(.PAD_VAL(4'h0)) dut0 (.clk_i(clk), .reset_i(reset), .bus(bus.slave));
  nibble_packer #(.PAD_VAL(4'hF)) dutF (.clk_i(clk), .reset_i(reset), .bus(busF.slave));

  // The pad-F instance sees exactly the same stimulus as the pad-0 one.
  assign busF.in_valid  = bus.in_valid;
  assign busF.in_nib    = bus.in_nib;
  assign busF.flush     = bus.flush;
  assign busF.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] n, input logic f, input logic r);
    bus.in_valid  = v;
    bus.in_nib    = n;
    bus.flush     = f;
    bus.out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checkCnt = 0;
    passCnt  = 0;
    failCnt  = 0;
    reset    = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;

    checkOutput("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_count", {28'b0, bus.out_count}, 32'd0);
    checkOutput("rst_nctr",  {27'b0, bus.nctr}, 32'd0);
    checkOutput("rst_word0", bus.out_word, 32'h00000000);
    checkOutput("rst_wordF", busF.out_word, 32'hFFFFFFFF);
    checkOutput("rst_ready", {31'b0, bus.in_ready}, 32'd1);

    // Full word 1..8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
      checkOutput("full_nctr_step", {27'b0, bus.nctr}, 32'(4 * (i - 1)));
      cycle();
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("full_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("full_word",  bus.out_word, 32'h87654321);
    checkOutput("full_count", {28'b0, bus.out_count}, 32'd8);
    checkOutput("full_nctr",  {27'b0, bus.nctr}, 32'd0);
    checkOutput("full_ready", {31'b0, bus.in_ready}, 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("take_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("take_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("take_word",  bus.out_word, 32'h00000000);
    checkOutput("take_count", {28'b0, bus.out_count}, 32'd0);

    // Partial flush A,B,C
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0); cycle();
    applyStimulus(1'b1, 4'hB, 1'b0, 1'b0); cycle();
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0); cycle();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0); cycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("pflush_valid",  {31'b0, bus.out_valid}, 32'd1);
    checkOutput("pflush_word0",  bus.out_word, 32'h00000CBA);
    checkOutput("pflush_count",  {28'b0, bus.out_count}, 32'd3);
    checkOutput("pflush_wordF",  busF.out_word, 32'hFFFFFCBA);
    checkOutput("pflush_countF", {28'b0, busF.out_count}, 32'd3);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1); cycle();

    // Flush with nothing held
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0); cycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("zflush_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("zflush_ready", {31'b0, bus.in_ready}, 32'd1);

    // Flush with the 2nd accept
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0); cycle();
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b0); cycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("f2_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("f2_word",  bus.out_word, 32'h00000097);
    checkOutput("f2_count", {28'b0, bus.out_count}, 32'd2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1); cycle();

    // Flush with the 8th accept, then held under backpressure
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), (i == 8), 1'b0);
      cycle();
    end
    checkOutput("f8_count", {28'b0, bus.out_count}, 32'd8);
    checkOutput("f8_word",  bus.out_word, 32'h87654321);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
      cycle();
      checkOutput("bp_ready", {31'b0, bus.in_ready}, 32'd0);
      checkOutput("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("bp_word",  bus.out_word, 32'h87654321);
      checkOutput("bp_count", {28'b0, bus.out_count}, 32'd8);
    end
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b1); cycle();
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    checkOutput("bp_take_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("bp_take_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("bp_take_word",  bus.out_word, 32'h00000000);
    cycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("bp_first_word", bus.out_word, 32'h00000005);
    checkOutput("bp_first_nctr", {27'b0, bus.nctr}, 32'd4);

    // Reset mid-fill after 5 nibbles held
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
      cycle();
    end
    checkOutput("mid_nctr_pre", {27'b0, bus.nctr}, 32'd20);
    reset = 1'b1;
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
    cycle();
    reset = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("mid_nctr",  {27'b0, bus.nctr}, 32'd0);
    checkOutput("mid_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid_word",  bus.out_word, 32'h00000000);
    cycle();
    checkOutput("mid_valid2", {31'b0, bus.out_valid}, 32'd0);
    for (int i = 8; i >= 1; i--) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("rev_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("rev_word",  bus.out_word, 32'h12345678);
    checkOutput("rev_count", {28'b0, bus.out_count}, 32'd8);

    // Reset while holding a full word
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("rfull_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rfull_count", {28'b0, bus.out_count}, 32'd0);
    checkOutput("rfull_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rfull_wordF", busF.out_word, 32'hFFFFFFFF);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Assembles a stream of 4-bit nibbles into 32-bit words, LSB nibble first, with ready/valid handshakes on both sides. It is the write-side counterpart of the 0..28 step-4 nibble-offset sequencer used by the word unpacking path. It sits between the nibble producer (audio/command decode path) and any 32-bit word consumer in the game logic. A flush input closes a partially filled word early.

## Interface
- PAD_VAL, default 4'h0: value placed in nibble slots that were never written when a word is closed by flush.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- in_valid  in  1  producer offers in_nib this cycle.
- in_nib  in  4  nibble data.
- in_ready  out  1  packer accepts a nibble this cycle; accept = in_valid & in_ready.
- flush  in  1  close the current partial word (single-cycle pulse or level).
- out_valid  out  1  out_word/out_count hold a completed word.
- out_word  out  32  assembled word; nibble k at bits [4k+3:4k].
- out_count  out  4  number of written nibbles in out_word, 1..8; 0 when idle.
- out_ready  in  1  consumer takes the word; take = out_valid & out_ready.
- nctr  out  5  bit offset of the next write slot: 0,4,...,28.

## Operation
- Two states: FILL (collecting) and FULL (holding a word for the consumer).
- in_ready = 1 in FILL, 0 in FULL. It is a combinational decode of the state register, with no bypass from out_ready.
- FILL, on accept:
  - write in_nib into out_word[nctr+3:nctr];
  - if nctr < 28: nctr <= nctr + 4;
  - if nctr == 28: nctr <= 0, out_count <= 8, go to FULL.
- FILL, flush = 1 and at least one nibble is held (nctr != 0, or an accept happens in the same cycle):
  - the same-cycle accept is written first;
  - out_count <= number of nibbles written, including that accept;
  - nctr <= 0; go to FULL.
  - Unwritten slots already hold PAD_VAL.
- FILL, flush = 1 with zero nibbles held and no accept: ignored, no word produced.
- Flush coinciding with the 8th accept: behaves as a normal full word (out_count = 8).
- FULL:
  - out_valid = 1; out_word and out_count are held stable;
  - in_valid and flush are ignored.
- FULL, on take:
  - go to FILL;
  - out_word <= all slots PAD_VAL; out_count <= 0; nctr <= 0.
- out_valid is registered and equals (state == FULL).
- In FILL, out_word shows the partial word with PAD_VAL in unwritten slots. Consumers must qualify out_word with out_valid.
- Arithmetic: nctr is 5-bit and only takes multiples of 4 in 0..28. It never wraps through +4; the 28 -> 0 transition is explicit. out_count is 4-bit, max 8.

## Timing
- Reset (reset high at a posedge), next cycle:
  - state FILL, nctr = 0, out_valid = 0, out_count = 0;
  - out_word = {8{PAD_VAL}}, in_ready = 1.
- Inputs are ignored in any cycle where reset is high. Reset mid-fill or mid-FULL discards the held data, and no word is emitted.
- Latency: out_valid rises the cycle after the 8th accept, or after the accepted flush.
- Throughput: with in_valid and out_ready held high, one word per 9 cycles (8 accepts plus 1 FULL cycle).
- Backpressure: out_valid stays high and out_word/out_count stay unchanged until take. in_ready stays 0 for the whole interval.
- After take, in_ready is 1 in the very next cycle.

## Test plan
- **Full word:** reset, then accept nibbles 1,2,...,8 on consecutive cycles.
  - out_valid = 1 the next cycle with out_word = 0x87654321 and out_count = 8.
  - nctr steps 0,4,...,28, then back to 0.
- **Partial flush:** PAD_VAL = 0; accept A, B, C, then pulse flush.
  - out_word = 0x00000CBA, out_count = 3.
  - Repeat with PAD_VAL = F: expect 0xFFFFFCBA.
- **Backpressure:** complete a word with out_ready = 0 for 5 cycles while in_valid = 1 with nibble 0x5.
  - in_ready = 0 and out_word is unchanged throughout.
  - After out_ready = 1: one take, then in_ready = 1; the first nibble accepted afterwards lands at bits [3:0].
- **Flush edge cases:**
  - flush with zero nibbles held: no out_valid.
  - flush in the same cycle as the 2nd accept (nibbles 7, 9): out_word = 0x00000097, out_count = 2.
  - flush with the 8th accept: out_count = 8.
- **Reset mid-fill:** accept 5 nibbles, then assert reset for 1 cycle.
  - nctr = 0, out_valid = 0, and no word is emitted.
  - The next 8 nibbles 8..1 give out_word = 0x12345678.
- **Reset while FULL:** reset with out_valid = 1 and out_ready = 0.
  - Next cycle out_valid = 0, out_count = 0, in_ready = 1.
